display_scan_mux: RTL and testbench

- Upstream stage of the BCD-to-7-segment decoder on the alarm-clock board.
- Time-multiplexes four BCD digits (HH:MM or MM:SS) onto a 4-digit common-anode display.
- Each refresh slot presents one 4-bit BCD code on `led` for the decoder and drives the matching active-low anode and decimal point.
- Adds anti-ghosting dead time, frame-coherent digit capture and leading-zero blanking. Blanked digits are sent as 4'hF, which the decoder renders all-off.

---
 rtl/display_scan_mux.sv | 119 +++++++++++
 tb/tb_display_scan_mux.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/display_scan_mux.sv
// Four-digit BCD scan multiplexer: dead time, frame-coherent capture, leading-zero blanking.
// Optional digit blinking is compiled in with `define DISP_BLINK_EN.
module display_scan_mux #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int BLINK_FRAMES = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_in,
    input  logic        lz_en,
    input  logic [3:0]  blink_mask,
    output logic [3:0]  led,
    output logic [3:0]  an,
    output logic        dp
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [15:0]   snapshot;
    logic [3:0]    dp_snap;

    logic          slot_end;
    logic          frame_start;
    logic          blink_hide;
    logic [3:0]    sup;
    logic [3:0]    nib;
    logic [3:0]    led_nxt;
    logic [3:0]    an_nxt;
    logic          dp_nxt;

    assign slot_end    = (cnt == CNT_LAST);
    assign frame_start = (idx == 2'd0) && (cnt == '0);

`ifdef DISP_BLINK_EN
    localparam int FW = $clog2(BLINK_FRAMES + 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    logic [FW-1:0] frame_cnt;
    logic          blink_phase;

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (slot_end && (idx == 2'd3)) begin
            if (frame_cnt == FRAME_LAST) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // mask is live so the field can change without waiting a frame
    assign blink_hide = ~blink_phase & blink_mask[idx];
`else
    logic unused_blink;
    assign unused_blink = ^blink_mask;
    assign blink_hide   = 1'b0;
`endif

    // a digit is dark only while every digit to its left is also zero
    always_comb begin
        sup    = 4'b0000;
        sup[3] = lz_en && (snapshot[15:12] == 4'h0);
        sup[2] = sup[3] && (snapshot[11:8] == 4'h0);
        sup[1] = sup[2] && (snapshot[7:4] == 4'h0);
    end

    always_comb begin
        nib     = 4'hF;
        led_nxt = 4'hF;
        an_nxt  = 4'b1111;
        dp_nxt  = 1'b1;
        case (idx)
            2'd0:    nib = snapshot[3:0];
            2'd1:    nib = snapshot[7:4];
            2'd2:    nib = snapshot[11:8];
            default: nib = snapshot[15:12];
        endcase
        if (!(cnt < CNT_BLANK) && !blink_hide) begin
            an_nxt  = ~(4'b0001 << idx);
            led_nxt = sup[idx] ? 4'hF : nib;
            dp_nxt  = ~dp_snap[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            idx      <= 2'd0;
            snapshot <= 16'h0000;
            dp_snap  <= 4'b0000;
            led      <= 4'hF;
            an       <= 4'b1111;
            dp       <= 1'b1;
        end else begin
            cnt <= slot_end ? '0 : cnt + 1'b1;
            if (slot_end) begin
                idx <= idx + 2'd1;
            end
            if (frame_start) begin
                snapshot <= digits;
                dp_snap  <= dp_in;
            end
            led <= led_nxt;
            an  <= an_nxt;
            dp  <= dp_nxt;
        end
    end

endmodule

// File: tb/tb_display_scan_mux.sv
// Directed bench for display_scan_mux with REFRESH_DIV=8, BLANK_CYCLES=2, BLINK_FRAMES=2.
module tb_display_scan_mux;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] digits;
    logic [3:0]  dp_in;
    logic        lz_en;
    logic [3:0]  blink_mask;
    logic [3:0]  led;
    logic [3:0]  an;
    logic        dp;

    int checks = 0;
    int errors = 0;

    display_scan_mux #(
        .REFRESH_DIV (8),
        .BLANK_CYCLES(2),
        .BLINK_FRAMES(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .digits    (digits),
        .dp_in     (dp_in),
        .lz_en     (lz_en),
        .blink_mask(blink_mask),
        .led       (led),
        .an        (an),
        .dp        (dp)
    );

    always #5 clk = ~clk;

    task automatic span(input string tag, input int n, input logic [3:0] eled,
                        input logic [3:0] ean, input logic edp);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            checks++;
            assert (led === eled) else begin
                errors++;
                $error("FAIL %s led got %h want %h", tag, led, eled);
            end
            checks++;
            assert (an === ean) else begin
                errors++;
                $error("FAIL %s an got %b want %b", tag, an, ean);
            end
            checks++;
            assert (dp === edp) else begin
                errors++;
                $error("FAIL %s dp got %b want %b", tag, dp, edp);
            end
        end
    endtask

    task automatic slot(input string tag, input logic [3:0] eled,
                        input logic [3:0] ean, input logic edp);
        span({tag, "_dead"}, 2, 4'hF, 4'b1111, 1'b1);
        span(tag, 6, eled, ean, edp);
    endtask

    // v: expected led per digit; dpn: expected active-low dp per digit; dark: slot fully off
    task automatic frame(input string tag, input logic [15:0] v, input logic [3:0] dpn,
                         input logic [3:0] dark);
        logic [3:0] a;
        for (int i = 0; i < 4; i++) begin
            a    = 4'b1111;
            a[i] = 1'b0;
            if (dark[i])
                slot($sformatf("%s_d%0d", tag, i), 4'hF, 4'b1111, 1'b1);
            else
                slot($sformatf("%s_d%0d", tag, i), v[4*i +: 4], a, dpn[i]);
        end
    endtask

    initial begin
        reset      = 1'b1;
        digits     = 16'h1234;
        dp_in      = 4'b0000;
        lz_en      = 1'b0;
        blink_mask = 4'b0000;

        span("reset_hold", 3, 4'hF, 4'b1111, 1'b1);
        reset = 1'b0;

        // first frame, digits change while digit1 is lit
        slot("a_d0", 4'h4, 4'b1110, 1'b1);
        span("a_d1_dead", 2, 4'hF, 4'b1111, 1'b1);
        span("a_d1", 3, 4'h3, 4'b1101, 1'b1);
        digits = 16'h5678;
        span("a_d1", 3, 4'h3, 4'b1101, 1'b1);
        slot("a_d2", 4'h2, 4'b1011, 1'b1);
        slot("a_d3", 4'h1, 4'b0111, 1'b1);
        frame("b", 16'h5678, 4'b1111, 4'b0000);

        // leading-zero suppression
        lz_en  = 1'b1;
        digits = 16'h0005;
        frame("lz5", 16'hFFF5, 4'b1111, 4'b0000);
        digits = 16'h0000;
        frame("lz0", 16'hFFF0, 4'b1111, 4'b0000);
        digits = 16'h0102;
        frame("lz102", 16'hF102, 4'b1111, 4'b0000);

        // decimal point on digit2 only
        lz_en  = 1'b0;
        digits = 16'h1230;
        dp_in  = 4'b0100;
        frame("dp", 16'h1230, 4'b1011, 4'b0000);

        // reset in the middle of digit2's slot (state cnt=5)
        slot("r_d0", 4'h0, 4'b1110, 1'b1);
        slot("r_d1", 4'h3, 4'b1101, 1'b1);
        span("r_d2_dead", 2, 4'hF, 4'b1111, 1'b1);
        span("r_d2", 3, 4'h2, 4'b1011, 1'b0);
        reset  = 1'b1;
        digits = 16'h9876;
        span("reset_mid", 2, 4'hF, 4'b1111, 1'b1);
        reset = 1'b0;
        frame("post_rst", 16'h9876, 4'b1011, 4'b0000);

        // blink on digits 1 and 0
        blink_mask = 4'b0011;
`ifdef DISP_BLINK_EN
        frame("blk_h", 16'h9876, 4'b1011, 4'b0000);
        frame("blk_i", 16'h9876, 4'b1011, 4'b0011);
        frame("blk_j", 16'h9876, 4'b1011, 4'b0011);
        frame("blk_k", 16'h9876, 4'b1011, 4'b0000);
        frame("blk_l", 16'h9876, 4'b1011, 4'b0000);
`else
        frame("noblk_h", 16'h9876, 4'b1011, 4'b0000);
        frame("noblk_i", 16'h9876, 4'b1011, 4'b0000);
        frame("noblk_j", 16'h9876, 4'b1011, 4'b0000);
        frame("noblk_k", 16'h9876, 4'b1011, 4'b0000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
